ahb_slave_read: RTL and testbench

AHB-Lite slave read path for the encryption accelerator and the counterpart of the slave write path. It decodes read transfers and returns cipher-text words from the output FIFO head, a status word and an optional completed-block counter on HRDATA. Reading the last cipher word pops the FIFO. It inserts wait states while the FIFO is empty and issues a two-cycle ERROR response on a bad address or a wait timeout.

---
 rtl/ahb_slave_read.sv | 149 ++++++++++++++
 tb/tb_ahb_slave_read.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_read.sv
// ahb_slave_read: AHB-Lite read slave returning cipher words, status
// and, when SLAVE_READ_BLKCNT_EN is defined, a block counter at 0x58.
module ahb_slave_read #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         HSELx,
    input  logic [31:0]  HADDR,
    input  logic         HWRITE,
    input  logic [1:0]   HTRANS,
    input  logic         HREADY,
    input  logic [127:0] cipher_text,
    input  logic         fifo_empty,
    input  logic         fifo_full,
    input  logic         busy,
    output logic [31:0]  HRDATA,
    output logic         HREADYOUT,
    output logic         HRESP,
    output logic         fifo_read,
    output logic         read_error
);

    localparam logic [4:0] TO = 5'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, DATA, WAIT, ERR1, ERR2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     start;
    logic [7:0] addr_q;
    logic [4:0] wcnt;
    logic [4:0] wcnt_nxt;
    logic       take;
    logic       in_data;
    logic       stall;
    logic       complete;
    logic       unused_addr;

    assign unused_addr = ^HADDR[31:8];

    function automatic logic is_cipher(input logic [7:0] a);
        return (a == 8'h44) || (a == 8'h48) ||
               (a == 8'h4C) || (a == 8'h50);
    endfunction

    function automatic logic is_valid(input logic [7:0] a);
`ifdef SLAVE_READ_BLKCNT_EN
        return is_cipher(a) || (a == 8'h54) || (a == 8'h58);
`else
        return is_cipher(a) || (a == 8'h54);
`endif
    endfunction

    // Handshake: stall only on cipher words while the FIFO is empty
    always_comb begin
        in_data   = (state == DATA) || (state == WAIT);
        stall     = in_data && is_cipher(addr_q) && fifo_empty;
        complete  = in_data && !stall;
        HREADYOUT = !(stall || (state == ERR1));
        HRESP     = (state == ERR1) || (state == ERR2);
        read_error = HRESP;
        fifo_read = complete && (addr_q == 8'h50);
        take      = HSELx && HREADY && HTRANS[1] &&
                    !HWRITE && HREADYOUT;
        start     = is_valid(HADDR[7:0]) ? DATA : ERR1;
    end

    // State and wait counter registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Latch the decoded address bits of each accepted read
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            addr_q <= '0;
        else if (take)
            addr_q <= HADDR[7:0];
    end

    // Next state: data beats a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            IDLE: begin
                if (take)
                    state_nxt = start;
            end
            DATA, WAIT: begin
                if (stall) begin
                    wcnt_nxt = wcnt + 5'd1;
                    if (wcnt_nxt == TO) begin
                        state_nxt = ERR1;
                        wcnt_nxt  = '0;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    wcnt_nxt  = '0;
                    state_nxt = take ? start : IDLE;
                end
            end
            ERR1: state_nxt = ERR2;
            ERR2: state_nxt = take ? start : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SLAVE_READ_BLKCNT_EN
    logic [15:0] blkcnt;

    // Count popped blocks, wrapping at 16 bits
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            blkcnt <= '0;
        else if (fifo_read)
            blkcnt <= blkcnt + 16'd1;
    end
`endif

    // Read data mux, zero outside completing data phases
    always_comb begin
        HRDATA = '0;
        if (complete) begin
            case (addr_q)
                8'h44: HRDATA = cipher_text[31:0];
                8'h48: HRDATA = cipher_text[63:32];
                8'h4C: HRDATA = cipher_text[95:64];
                8'h50: HRDATA = cipher_text[127:96];
                8'h54: HRDATA = {29'b0, fifo_full, fifo_empty, busy};
`ifdef SLAVE_READ_BLKCNT_EN
                8'h58: HRDATA = {16'b0, blkcnt};
`endif
                default: HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_read.sv
// tb_ahb_slave_read: directed and random reads against a
// transfer-level model of the read slave.
module tb_ahb_slave_read;

    localparam int TO = 16;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         HSELx = 1'b0;
    logic [31:0]  HADDR = '0;
    logic         HWRITE = 1'b0;
    logic [1:0]   HTRANS = 2'b00;
    logic [127:0] cipher_text = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_full = 1'b0;
    logic         busy = 1'b0;
    wire  [31:0]  HRDATA;
    wire          HREADYOUT;
    wire          HRESP;
    wire          fifo_read;
    wire          read_error;

    ahb_slave_read #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .HSELx(HSELx),
        .HADDR(HADDR),
        .HWRITE(HWRITE),
        .HTRANS(HTRANS),
        .HREADY(HREADYOUT),
        .cipher_text(cipher_text),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .busy(busy),
        .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP(HRESP),
        .fifo_read(fifo_read),
        .read_error(read_error)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int passed = 0;

    // Environment / directed-request state
    logic [127:0] fq[$];
    logic [127:0] pw[8];
    int   push_seq = 0;
    int   push_done = 0;
    bit   rand_env = 0;
    bit   drought = 0;
    bit   busy_dir = 0;
    bit   pop_seen = 0;
    int   cyc = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;

    // Literal expectation mailbox
    string       l_nm = "";
    logic        l_rdy = 1'b1;
    logic        l_resp = 1'b0;
    logic        l_pop = 1'b0;
    logic [31:0] l_d = '0;
    int          lit_seq = 0;
    int          lit_done = 0;

    // Model state: 0 none, 1 data, 2 err1, 3 err2
    int          m_phase = 0;
    int          m_waits = 0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_blk = '0;

    function automatic bit is_ciph(input logic [7:0] a);
        return a == 8'h44 || a == 8'h48 || a == 8'h4C || a == 8'h50;
    endfunction

    function automatic bit is_ok(input logic [7:0] a);
`ifdef SLAVE_READ_BLKCNT_EN
        return is_ciph(a) || a == 8'h54 || a == 8'h58;
`else
        return is_ciph(a) || a == 8'h54;
`endif
    endfunction

    function automatic logic [31:0] word_at(
        input logic [7:0] a, input logic [127:0] h,
        input logic [2:0] st, input logic [15:0] blk);
        int idx;
        if (is_ciph(a)) begin
            idx = (int'(a) - 'h44) / 4;
            return 32'(h >> (32 * idx));
        end
        if (a == 8'h54) return {29'b0, st};
        if (a == 8'h58) return {16'b0, blk};
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // FIFO / status environment, updated just after each edge
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (pop_seen && fq.size() > 0) void'(fq.pop_front());
            if (push_done != push_seq) begin
                fq.push_back(pw[push_done % 8]);
                push_done++;
            end else if (rand_env && fq.size() < 4 && !drought &&
                         $urandom_range(0, 2) == 0) begin
                fq.push_back({$urandom, $urandom, $urandom, $urandom});
            end
            if (rand_env) begin
                cyc++;
                if (cyc % 64 == 0) drought = ($urandom_range(0, 3) == 0);
                busy = 1'($urandom_range(0, 1));
            end else begin
                busy = busy_dir;
            end
            fifo_empty  = (fq.size() == 0);
            cipher_text = fifo_empty ? '0 : fq[0];
            fifo_full   = (fq.size() >= 4);
        end
    end

    // Compare process: predict and check every cycle
    initial begin
        logic        e_rdy;
        logic        e_resp;
        logic        e_pop;
        logic [31:0] e_d;
        bit          stall;
        forever begin
            @(negedge HCLK or negedge HRESETn);
            if (!HRESETn) begin
                m_phase = 0;
                m_waits = 0;
                m_blk = '0;
                pop_seen = 0;
                #1;
                chk("rst_hreadyout", 32'(HREADYOUT), 1);
                chk("rst_hresp", 32'(HRESP), 0);
                chk("rst_hrdata", HRDATA, 0);
                chk("rst_fifo_read", 32'(fifo_read), 0);
                chk("rst_read_error", 32'(read_error), 0);
            end else begin
                e_rdy = 1; e_resp = 0; e_pop = 0; e_d = '0; stall = 0;
                if (m_phase == 1) begin
                    if (is_ciph(m_addr) && fifo_empty) begin
                        e_rdy = 0;
                        stall = 1;
                    end else begin
                        e_d = word_at(m_addr, cipher_text,
                                      {fifo_full, fifo_empty, busy}, m_blk);
                        e_pop = (m_addr == 8'h50);
                    end
                end else if (m_phase == 2) begin
                    e_rdy = 0;
                    e_resp = 1;
                end else if (m_phase == 3) begin
                    e_resp = 1;
                end
                chk("hreadyout", 32'(HREADYOUT), 32'(e_rdy));
                chk("hresp", 32'(HRESP), 32'(e_resp));
                chk("read_error", 32'(read_error), 32'(e_resp));
                chk("hrdata", HRDATA, e_d);
                chk("fifo_read", 32'(fifo_read), 32'(e_pop));
                if (lit_seq != lit_done) begin
                    chk({l_nm, "_rdy"}, 32'(HREADYOUT), 32'(l_rdy));
                    chk({l_nm, "_resp"}, 32'(HRESP), 32'(l_resp));
                    chk({l_nm, "_data"}, HRDATA, l_d);
                    chk({l_nm, "_pop"}, 32'(fifo_read), 32'(l_pop));
                    lit_done = lit_seq;
                end
                if (tmo_cnt != tmo_seen) begin
                    chk("bus_timeout", 32'(tmo_cnt), 32'(tmo_seen));
                    tmo_seen = tmo_cnt;
                end
                pop_seen = fifo_read;
                if (stall) begin
                    m_waits++;
                    if (m_waits == TO) begin
                        m_phase = 2;
                        m_waits = 0;
                    end
                end else if (m_phase == 2) begin
                    m_phase = 3;
                end else begin
                    if (e_pop) m_blk++;
                    m_waits = 0;
                    if (HSELx && HTRANS[1] && !HWRITE) begin
                        m_phase = is_ok(HADDR[7:0]) ? 1 : 2;
                        m_addr = HADDR[7:0];
                    end else begin
                        m_phase = 0;
                    end
                end
            end
        end
    end

    task automatic step(input logic [7:0] a, input logic [1:0] t,
                        input logic w);
        logic [31:0] r;
        @(posedge HCLK);
        #2;
        r = $urandom;
        HADDR = {r[31:8], a};
        HTRANS = t;
        HWRITE = w;
        HSELx = 1'b1;
    endtask

    task automatic lit(input string nm, input logic r, input logic rs,
                       input logic [31:0] d, input logic p);
        l_nm = nm; l_rdy = r; l_resp = rs; l_d = d; l_pop = p;
        lit_seq++;
        @(negedge HCLK);
        #1;
    endtask

    task automatic push(input logic [127:0] w);
        pw[push_seq % 8] = w;
        push_seq++;
    endtask

    task automatic xfer(input logic [7:0] a, input logic [1:0] t,
                        input logic s, input logic w);
        int n = 0;
        step(a, t, w);
        HSELx = s;
        do begin
            @(negedge HCLK);
            n++;
        end while (!HREADYOUT && n < 100);
        if (!HREADYOUT) tmo_cnt++;
    endtask

    localparam logic [127:0] HEAD =
        128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] WW =
        128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    initial begin
        logic [7:0] tbl[10];
        logic [7:0] a;
        tbl = '{8'h44, 8'h48, 8'h4C, 8'h50, 8'h54,
                8'h58, 8'h60, 8'h00, 8'h5C, 8'h40};
        repeat (3) @(posedge HCLK);
        #2 HRESETn = 1'b1;

        step(8'h54, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        lit("status_empty", 1, 0, 32'h0000_0002, 0);

        push(HEAD);
        step(8'h44, 2'b10, 0);
        step(8'h48, 2'b11, 0);
        lit("burst_w0", 1, 0, 32'hCCDD_EEFF, 0);
        step(8'h4C, 2'b11, 0);
        lit("burst_w1", 1, 0, 32'h8899_AABB, 0);
        step(8'h50, 2'b11, 0);
        lit("burst_w2", 1, 0, 32'h4455_6677, 0);
        step(8'h00, 2'b00, 0);
        lit("burst_w3", 1, 0, 32'h0011_2233, 1);
        lit("burst_end", 1, 0, 0, 0);

        step(8'h44, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        for (int i = 0; i < 3; i++) lit("wait3", 0, 0, 0, 0);
        push(WW);
        lit("wait3_data", 1, 0, 32'hD0D1_D2D3, 0);
        step(8'h50, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        lit("drain", 1, 0, 32'hA0A1_A2A3, 1);

        step(8'h50, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        for (int i = 0; i < TO; i++) lit("tmo_wait", 0, 0, 0, 0);
        lit("tmo_err1", 0, 1, 0, 0);
        lit("tmo_err2", 1, 1, 0, 0);
        lit("tmo_end", 1, 0, 0, 0);

        step(8'h60, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        lit("bad_err1", 0, 1, 0, 0);
        lit("bad_err2", 1, 1, 0, 0);

        step(8'h44, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        lit("rst_wait", 0, 0, 0, 0);
        lit("rst_wait", 0, 0, 0, 0);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #2 HRESETn = 1'b1;
        busy_dir = 1;
        step(8'h54, 2'b10, 0);
        step(8'h00, 2'b00, 0);
        lit("status_busy", 1, 0, 32'h0000_0003, 0);
        busy_dir = 0;

        push(HEAD);
        push(WW);
        push(~HEAD);
        repeat (4) @(posedge HCLK);
        step(8'h50, 2'b10, 0);
        step(8'h50, 2'b10, 0);
        lit("blk_pop0", 1, 0, 32'h0011_2233, 1);
        step(8'h50, 2'b10, 0);
        lit("blk_pop1", 1, 0, 32'hA0A1_A2A3, 1);
        step(8'h58, 2'b10, 0);
        lit("blk_pop2", 1, 0, 32'hFFEE_DDCC, 1);
        step(8'h00, 2'b00, 0);
`ifdef SLAVE_READ_BLKCNT_EN
        lit("blkcnt", 1, 0, 32'h0000_0003, 0);
`else
        lit("blk_err1", 0, 1, 0, 0);
        lit("blk_err2", 1, 1, 0, 0);
`endif

        rand_env = 1;
        for (int i = 0; i < 2500; i++) begin
            a = tbl[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            xfer(a, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0));
        end
        xfer(8'h00, 2'b00, 0, 0);
        repeat (3) @(negedge HCLK);
        #2;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
